// File: rtl/vram_fill_sched.sv
// VRAM p1 port owner: CPU/fill-engine arbitration (CPU first) and vblank-aligned
// back-buffer swap that never lands while a rectangle fill is in flight.
module vram_fill_sched #(
   parameter int unsigned ROW_BYTES = 320,
   parameter int unsigned ROWS      = 480,
   parameter int unsigned AW        = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   input  logic          cpu_we,
   input  logic          cpu_re,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_rvalid,
   input  logic [8:0]    fill_xb,
   input  logic [8:0]    fill_y,
   input  logic [8:0]    fill_w,
   input  logic [8:0]    fill_h,
   input  logic [7:0]    fill_val,
   input  logic          fill_rq,
   output logic          fill_busy,
   output logic          fill_done,
   output logic          fill_err,
   input  logic          swap_rq,
   output logic          swap_ack,
   input  logic          vblank,
   output logic          bufswap,
   output logic [AW-1:0] vm_addr,
   output logic [7:0]    vm_wdata,
   output logic          vm_we,
   output logic          vm_re,
   input  logic [7:0]    vm_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RUN,
      DONE
   } state_t;

   localparam logic [9:0]    ROW_LIM  = 10'(ROW_BYTES);
   localparam logic [9:0]    ROW_CNT  = 10'(ROWS);
   localparam logic [AW-1:0] ROW_STEP = AW'(ROW_BYTES);

   state_t        state;
   state_t        state_n;

   logic [8:0]    xb_q;
   logic [8:0]    y_q;
   logic [8:0]    w_q;
   logic [8:0]    h_q;
   logic [7:0]    val_q;
   logic          err_q;
   logic [AW-1:0] row_base;
   logic [AW-1:0] addr;
   logic [8:0]    col;
   logic [8:0]    row;

   logic          cpu_acc;
   logic          accept;
   logic          grant;
   logic          empty_rect;
   logic          bad_rect;
   logic          last_byte;
   logic [9:0]    x_end;
   logic [9:0]    y_end;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] next_base;

   logic          vblank_d;
   logic          swap_pend;
   logic          swap_fire;

   assign cpu_acc    = cpu_we | cpu_re;
   // Extents are summed in 10 bits so 9-bit operands can never wrap into range.
   assign x_end      = {1'b0, xb_q} + {1'b0, w_q};
   assign y_end      = {1'b0, y_q} + {1'b0, h_q};
   assign empty_rect = (w_q == '0) || (h_q == '0);
   assign bad_rect   = (x_end > ROW_LIM) || (y_end > ROW_CNT);
   assign last_byte  = (col == 9'd1) && (row == 9'd1);
   assign start_addr = AW'(y_q) * ROW_STEP + AW'(xb_q);
   assign next_base  = row_base + ROW_STEP;

   assign fill_busy  = (state != IDLE);
   assign fill_done  = (state == DONE);
   assign fill_err   = (state == DONE) & err_q;
   assign cpu_rdata  = cpu_rvalid ? vm_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      grant   = 1'b0;
      case (state)
         IDLE: begin
            if (fill_rq) begin
               accept  = 1'b1;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (empty_rect || bad_rect) begin
               state_n = DONE;
            end else begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (!cpu_acc) begin
               grant = 1'b1;
               if (last_byte) begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Fill datapath: argument latch, range decision and the row/column walk.
   always_ff @(posedge clk) begin
      if (!rst) begin
         xb_q     <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         val_q    <= '0;
         err_q    <= 1'b0;
         row_base <= '0;
         addr     <= '0;
         col      <= '0;
         row      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  xb_q  <= fill_xb;
                  y_q   <= fill_y;
                  w_q   <= fill_w;
                  h_q   <= fill_h;
                  val_q <= fill_val;
                  err_q <= 1'b0;
               end
            end
            CHECK: begin
               err_q    <= !empty_rect && bad_rect;
               row_base <= start_addr;
               addr     <= start_addr;
               col      <= w_q;
               row      <= h_q;
            end
            RUN: begin
               if (grant) begin
                  if (col == 9'd1) begin
                     row_base <= next_base;
                     addr     <= next_base;
                     col      <= w_q;
                     row      <= row - 9'd1;
                  end else begin
                     addr <= addr + AW'(1);
                     col  <= col - 9'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered p1 port; a CPU access always displaces the fill engine.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vm_addr    <= '0;
         vm_wdata   <= '0;
         vm_we      <= 1'b0;
         vm_re      <= 1'b0;
         cpu_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= vm_re;
         vm_we      <= cpu_we | grant;
         vm_re      <= cpu_re & ~cpu_we;
         if (cpu_acc) begin
            vm_addr <= cpu_addr;
         end else if (grant) begin
            vm_addr <= addr;
         end
         if (cpu_we) begin
            vm_wdata <= cpu_wdata;
         end else if (grant) begin
            vm_wdata <= val_q;
         end
      end
   end

   assign swap_fire = swap_pend && vblank && !vblank_d && !fill_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vblank_d  <= 1'b0;
         swap_pend <= 1'b0;
         swap_ack  <= 1'b0;
         bufswap   <= 1'b0;
      end else begin
         vblank_d  <= vblank;
         swap_ack  <= swap_fire;
         swap_pend <= swap_fire ? 1'b0 : (swap_pend | swap_rq);
         if (swap_fire) begin
            bufswap <= ~bufswap;
         end
      end
   end

endmodule

// File: tb/tb_vram_fill_sched.sv
// Bench for vram_fill_sched: CPU port vector table, directed fill/swap sequences,
// and randomized CPU traffic over fills checked against a rectangle-level model.
module tb_vram_fill_sched;

   localparam int AW    = 20;
   localparam int RB    = 320;
   localparam int RS    = 480;
   localparam int CBASE = 200000;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_we;
   logic          cpu_re;
   logic [7:0]    cpu_rdata;
   logic          cpu_rvalid;
   logic [8:0]    fill_xb;
   logic [8:0]    fill_y;
   logic [8:0]    fill_w;
   logic [8:0]    fill_h;
   logic [7:0]    fill_val;
   logic          fill_rq;
   logic          fill_busy;
   logic          fill_done;
   logic          fill_err;
   logic          swap_rq;
   logic          swap_ack;
   logic          vblank;
   logic          bufswap;
   logic [AW-1:0] vm_addr;
   logic [7:0]    vm_wdata;
   logic          vm_we;
   logic          vm_re;
   logic [7:0]    vm_rdata;

   always #5 clk = ~clk;

   vram_fill_sched #(.ROW_BYTES(RB), .ROWS(RS), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .fill_xb(fill_xb), .fill_y(fill_y), .fill_w(fill_w), .fill_h(fill_h),
      .fill_val(fill_val), .fill_rq(fill_rq),
      .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
      .swap_rq(swap_rq), .swap_ack(swap_ack), .vblank(vblank), .bufswap(bufswap),
      .vm_addr(vm_addr), .vm_wdata(vm_wdata), .vm_we(vm_we), .vm_re(vm_re),
      .vm_rdata(vm_rdata)
   );

   // Behavioural VRAM on p1: read data registered one cycle after vm_re.
   bit [7:0] vram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (vm_we) vram[vm_addr] <= vm_wdata;
      if (vm_re) vm_rdata <= vram[vm_addr];
   end

   int checks = 0;
   int errors = 0;

   bit         rv_pipe = 1'b0;
   logic [7:0] rv_data = 8'h00;
   bit [7:0]   cmem [0:63];
   bit         ack_exp = 1'b0;
   bit         bs_exp  = 1'b0;

   typedef struct {
      bit         rstn;
      bit         we;
      bit         re;
      logic [19:0] a;
      logic [7:0] d;
      bit         xwe;
      bit         xre;
      logic [19:0] xa;
      logic [7:0] xd;
      bit         xrv;
      logic [7:0] xrd;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of CPU stimulus plus the expected fill write (if the model grants one).
   task automatic cyc(input bit we, input bit re, input int unsigned ci, input logic [7:0] d,
                      input bit fw, input logic [19:0] fa, input logic [7:0] fd);
      bit          xwe;
      bit          xre;
      logic [19:0] xa;
      logic [7:0]  xd;
      bit          rd_now;
      logic [7:0]  rd_val;
      cpu_we    = we;
      cpu_re    = re;
      cpu_addr  = 20'(CBASE + ci);
      cpu_wdata = d;
      rd_now    = re && !we;
      rd_val    = cmem[ci];
      xwe = 1'b0; xre = 1'b0; xa = '0; xd = '0;
      if (we) begin
         cmem[ci] = d;
         xwe = 1'b1; xa = 20'(CBASE + ci); xd = d;
      end else if (re) begin
         xre = 1'b1; xa = 20'(CBASE + ci);
      end else if (fw) begin
         xwe = 1'b1; xa = fa; xd = fd;
      end
      step();
      chk("vm_we", vm_we, xwe);
      chk("vm_re", vm_re, xre);
      if (xwe || xre) chk("vm_addr", vm_addr, xa);
      if (xwe) chk("vm_wdata", vm_wdata, xd);
      chk("cpu_rvalid", cpu_rvalid, rv_pipe);
      if (rv_pipe) chk("cpu_rdata", cpu_rdata, rv_data);
      chk("swap_ack", swap_ack, ack_exp);
      chk("bufswap", bufswap, bs_exp);
      rv_pipe = rd_now;
      rv_data = rd_val;
      ack_exp = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 8'h00, 1'b0, '0, 8'h00);
   endtask

   task automatic gen_cpu(output bit we, output bit re, output int unsigned ci, output logic [7:0] d);
      int unsigned r;
      r  = $urandom_range(0, 7);
      we = (r <= 1) || (r == 3);
      re = (r == 2) || (r == 3);
      ci = $urandom_range(0, 63);
      d  = 8'($urandom);
   endtask

   task automatic rand_cpu(input int n);
      bit we, re;
      int unsigned ci;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         gen_cpu(we, re, ci, d);
         cyc(we, re, ci, d, 1'b0, '0, 8'h00);
      end
   endtask

   // Model: rectangle byte list in raster order; accept at cycle 0, range decision at
   // cycle 1, one write per CPU-free cycle from cycle 2; done shows with the last write.
   // mode: 0 = CPU idle, 1 = CPU write every other cycle, 2 = random CPU traffic.
   task automatic run_fill(input int xb, input int y, input int w, input int h,
                           input logic [7:0] val, input int mode, input bit vbmode);
      int          q[$];
      bit          bad;
      bit          empty;
      int          remaining;
      int          done_at;
      int          limit;
      bit          seen;
      bit          we, re, fw;
      int unsigned ci;
      logic [7:0]  d;
      logic [19:0] fa;
      empty = (w == 0) || (h == 0);
      bad   = (xb + w > RB) || (y + h > RS);
      if (!empty && !bad)
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) q.push_back((y + r) * RB + xb + c);
      remaining = q.size();
      done_at   = (remaining == 0) ? 2 : -1;
      limit     = 3 * remaining + 40;
      seen      = 1'b0;
      fill_xb = 9'(xb); fill_y = 9'(y); fill_w = 9'(w); fill_h = 9'(h);
      fill_val = val;
      fill_rq  = 1'b1;
      for (int k = 0; k < limit; k++) begin
         we = 1'b0; re = 1'b0; ci = 0; d = 8'h00;
         if (mode == 1) begin
            we = (k % 2 == 0); ci = k % 64; d = 8'(k + 1);
         end else if (mode == 2) begin
            gen_cpu(we, re, ci, d);
         end
         fw = 1'b0; fa = '0;
         if (k >= 2 && remaining > 0 && !(we || re)) begin
            fw = 1'b1;
            fa = 20'(q.pop_front());
            remaining--;
            if (remaining == 0) done_at = k + 1;
         end
         if (vbmode) vblank = ((k / 512) % 2 == 1);
         cyc(we, re, ci, d, fw, fa, val);
         fill_rq = 1'b0;
         chk("fill_done", fill_done, (k + 1 == done_at));
         chk("fill_err", fill_err, (k + 1 == done_at) && bad && !empty);
         chk("fill_busy", fill_busy, (done_at < 0) || (k + 1 <= done_at));
         if (k + 1 == done_at) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL fill_timeout: actual no fill_done required done within %0d cycles", limit);
      end
      idle(1);
      chk("fill_busy_after", fill_busy, 1'b0);
      chk("fill_done_after", fill_done, 1'b0);
   endtask

   initial begin
      int unsigned start;
      rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
      fill_xb = '0; fill_y = '0; fill_w = '0; fill_h = '0; fill_val = '0; fill_rq = 1'b0;
      swap_rq = 1'b0; vblank = 1'b0;

      //          rstn we re addr      data    xwe xre xaddr     xdata  xrv xrdata
      tbl[0]  = '{1'b0,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b0,8'h00};
      tbl[1]  = '{1'b1,1'b1,1'b0,20'h00010,8'hA5, 1'b1,1'b0,20'h00010,8'hA5, 1'b0,8'h00};
      tbl[2]  = '{1'b1,1'b0,1'b1,20'h00010,8'h00, 1'b0,1'b1,20'h00010,8'h00, 1'b0,8'h00};
      tbl[3]  = '{1'b1,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b1,8'hA5};
      tbl[4]  = '{1'b1,1'b1,1'b1,20'h00020,8'h3C, 1'b1,1'b0,20'h00020,8'h3C, 1'b0,8'h00};
      tbl[5]  = '{1'b1,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b0,8'h00};
      tbl[6]  = '{1'b1,1'b0,1'b1,20'h00020,8'h00, 1'b0,1'b1,20'h00020,8'h00, 1'b0,8'h00};
      tbl[7]  = '{1'b1,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b1,8'h3C};
      tbl[8]  = '{1'b1,1'b1,1'b0,20'h00030,8'h5A, 1'b1,1'b0,20'h00030,8'h5A, 1'b0,8'h00};
      tbl[9]  = '{1'b1,1'b0,1'b1,20'h00030,8'h00, 1'b0,1'b1,20'h00030,8'h00, 1'b0,8'h00};
      tbl[10] = '{1'b1,1'b1,1'b0,20'h00031,8'h11, 1'b1,1'b0,20'h00031,8'h11, 1'b1,8'h5A};
      tbl[11] = '{1'b1,1'b0,1'b1,20'h00031,8'h00, 1'b0,1'b1,20'h00031,8'h00, 1'b0,8'h00};
      tbl[12] = '{1'b1,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b1,8'h11};
      tbl[13] = '{1'b0,1'b1,1'b0,20'h00040,8'hFF, 1'b0,1'b0,20'h00000,8'h00, 1'b0,8'h00};
      tbl[14] = '{1'b1,1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,20'h00000,8'h00, 1'b0,8'h00};

      repeat (3) step();
      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].rstn; cpu_we = tbl[i].we; cpu_re = tbl[i].re;
         cpu_addr = tbl[i].a; cpu_wdata = tbl[i].d;
         step();
         chk($sformatf("tbl%0d_vm_we", i), vm_we, tbl[i].xwe);
         chk($sformatf("tbl%0d_vm_re", i), vm_re, tbl[i].xre);
         if (tbl[i].xwe || tbl[i].xre || !tbl[i].rstn) chk($sformatf("tbl%0d_vm_addr", i), vm_addr, tbl[i].xa);
         if (tbl[i].xwe || !tbl[i].rstn) chk($sformatf("tbl%0d_vm_wdata", i), vm_wdata, tbl[i].xd);
         chk($sformatf("tbl%0d_rvalid", i), cpu_rvalid, tbl[i].xrv);
         if (tbl[i].xrv || !tbl[i].rstn) chk($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].xrd);
         chk($sformatf("tbl%0d_busy", i), fill_busy, 1'b0);
         chk($sformatf("tbl%0d_done", i), fill_done, 1'b0);
         chk($sformatf("tbl%0d_swap_ack", i), swap_ack, 1'b0);
         chk($sformatf("tbl%0d_bufswap", i), bufswap, 1'b0);
      end
      rst = 1'b1;

      // Directed fills: nominal, CPU-stalled, out of range, boundary, empty, 9-bit wrap.
      run_fill(10, 2, 3, 2, 8'h77, 0, 1'b0);
      run_fill(10, 2, 3, 2, 8'h77, 1, 1'b0);
      run_fill(318, 2, 3, 2, 8'h77, 0, 1'b0);
      run_fill(10, 479, 3, 2, 8'h77, 0, 1'b0);
      run_fill(317, 478, 3, 2, 8'h5E, 0, 1'b0);
      run_fill(5, 5, 0, 4, 8'h12, 0, 1'b0);
      run_fill(5, 5, 4, 0, 8'h12, 0, 1'b0);
      run_fill(300, 0, 300, 1, 8'h12, 0, 1'b0);
      run_fill(0, 0, 4, 3, 8'h9D, 2, 1'b0);

      // Basic swap at a vblank rising edge.
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0; idle(2);
      vblank = 1'b1; ack_exp = 1'b1; bs_exp = ~bs_exp; idle(1);
      idle(1); vblank = 1'b0; idle(2);

      // Repeated request while pending yields a single swap.
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0; idle(1);
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0; idle(1);
      vblank = 1'b1; ack_exp = 1'b1; bs_exp = ~bs_exp; idle(1);
      idle(1); vblank = 1'b0; idle(2);
      vblank = 1'b1; idle(2); vblank = 1'b0; idle(1);

      // Request raised in the ack cycle arms the next swap.
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0; idle(1);
      vblank = 1'b1; ack_exp = 1'b1; bs_exp = ~bs_exp; idle(1);
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0; idle(1);
      vblank = 1'b0; idle(1);
      vblank = 1'b1; ack_exp = 1'b1; bs_exp = ~bs_exp; idle(1);
      vblank = 1'b0; idle(2);

      // Swap requested before a 4000-byte fill crossing vblank edges: deferred past fill_done.
      swap_rq = 1'b1; idle(1); swap_rq = 1'b0;
      run_fill(0, 0, 200, 20, 8'h44, 0, 1'b1);
      vblank = 1'b0; idle(1);
      vblank = 1'b1; ack_exp = 1'b1; bs_exp = ~bs_exp; idle(1);
      vblank = 1'b0; idle(2);

      // Reset mid-fill with a swap pending and bufswap set.
      start = 40 * RB + 7;
      fill_xb = 9'd7; fill_y = 9'd40; fill_w = 9'd100; fill_h = 9'd10; fill_val = 8'hC3;
      fill_rq = 1'b1; idle(1); fill_rq = 1'b0; idle(1);
      for (int j = 0; j < 7; j++) begin
         swap_rq = (j == 2);
         cyc(1'b0, 1'b0, 0, 8'h00, 1'b1, 20'(start + j), 8'hC3);
      end
      swap_rq = 1'b0;
      rst = 1'b0; step();
      chk("rst_vm_we", vm_we, 1'b0);
      chk("rst_vm_re", vm_re, 1'b0);
      chk("rst_vm_addr", vm_addr, 0);
      chk("rst_vm_wdata", vm_wdata, 0);
      chk("rst_rvalid", cpu_rvalid, 1'b0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_busy", fill_busy, 1'b0);
      chk("rst_done", fill_done, 1'b0);
      chk("rst_err", fill_err, 1'b0);
      chk("rst_swap_ack", swap_ack, 1'b0);
      chk("rst_bufswap", bufswap, 1'b0);
      rst = 1'b1; rv_pipe = 1'b0; bs_exp = 1'b0;
      idle(3);
      chk("rst_fill_abandoned", fill_busy, 1'b0);
      vblank = 1'b1; idle(2); vblank = 1'b0; idle(1);

      // Randomized rectangles under random CPU traffic.
      for (int n = 0; n < 20; n++) begin
         int rx, ry, rw, rh;
         rx = ($urandom_range(0, 3) == 0) ? $urandom_range(310, 330) : $urandom_range(0, 300);
         ry = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 490) : $urandom_range(0, 460);
         rw = $urandom_range(0, 9);
         rh = $urandom_range(0, 6);
         run_fill(rx, ry, rw, rh, 8'($urandom), 2, 1'b0);
         rand_cpu($urandom_range(0, 5));
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
